// File: rtl/fft_pkg.sv
// Shared constants for the FFT twiddle-path multiplier.
//   TW_A_W / TW_B_W / TW_TAG_W : default operand and tag widths
//   prod_width()               : full product width for given operand widths
package fft_pkg;

  localparam int unsigned TW_A_W   = 16;
  localparam int unsigned TW_B_W   = 8;
  localparam int unsigned TW_TAG_W = 4;

  function automatic int unsigned prod_width(input int unsigned a_w,
                                             input int unsigned b_w);
    return a_w + b_w;
  endfunction

endpackage

// File: rtl/mult_stage.sv
// One stage of the shift-add multiplier pipeline. Retires the multiplier
// LSB presented at its input and registers the partial sum, the pre-shifted
// multiplicand, the remaining multiplier bits and the tag.
// Ports:
//   clk, rst             clock, async active-high reset
//   flush_i              synchronous clear of this stage
//   adv_i                pipeline advance (hold when low)
//   valid_i/acc_i/a_i/b_i/tag_i   state from the previous stage
//   valid_o/acc_o/a_o/b_o/tag_o   registered state for the next stage
module mult_stage #(
  parameter int unsigned P_W        = 24,
  parameter int unsigned B_W        = 8,
  parameter int unsigned TAG_W      = 4,
  parameter bit          IS_MSB_SUB = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             adv_i,
  input  logic             valid_i,
  input  logic [P_W-1:0]   acc_i,
  input  logic [P_W-1:0]   a_i,
  input  logic [B_W-1:0]   b_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  output logic [P_W-1:0]   acc_o,
  output logic [P_W-1:0]   a_o,
  output logic [B_W-1:0]   b_o,
  output logic [TAG_W-1:0] tag_o
);

  logic             valid_q, valid_d;
  logic [P_W-1:0]   acc_q,   acc_d;
  logic [P_W-1:0]   a_q,     a_d;
  logic [B_W-1:0]   b_q,     b_d;
  logic [TAG_W-1:0] tag_q,   tag_d;

  logic [P_W-1:0]   partial;
  logic [P_W-1:0]   acc_new;

  always_comb begin
    partial = b_i[0] ? a_i : '0;
    // In two's-complement mode the multiplier MSB carries weight -2^(B_W-1).
    if (IS_MSB_SUB) acc_new = acc_i - partial;
    else            acc_new = acc_i + partial;
  end

  always_comb begin
    valid_d = valid_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    tag_d   = tag_q;
    if (flush_i) begin
      valid_d = 1'b0;
      acc_d   = '0;
      a_d     = '0;
      b_d     = '0;
      tag_d   = '0;
    end else if (adv_i) begin
      if (valid_i) begin
        valid_d = 1'b1;
        acc_d   = acc_new;
        a_d     = a_i << 1;
        b_d     = b_i >> 1;
        tag_d   = tag_i;
      end else begin
        // Bubbles carry all-zero data so an idle output reads 0.
        valid_d = 1'b0;
        acc_d   = '0;
        a_d     = '0;
        b_d     = '0;
        tag_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
    end
  end

  assign valid_o = valid_q;
  assign acc_o   = acc_q;
  assign a_o     = a_q;
  assign b_o     = b_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/pipe_shift_add_mult.sv
// Fully pipelined A_W x B_W shift-add multiplier, one multiplier bit per
// stage, B_W stages of latency, one operation per cycle.
// Ports:
//   clk, rst            clock, async active-high reset
//   flush               synchronous discard of all in-flight operations
//   in_valid/in_ready   input handshake; in_a, in_b operands, in_tag user tag
//   out_valid/out_ready output handshake; out_p product, out_tag its tag
module pipe_shift_add_mult
  import fft_pkg::*;
#(
  parameter  int unsigned A_W    = TW_A_W,
  parameter  int unsigned B_W    = TW_B_W,
  parameter  int unsigned SIGNED = 0,
  parameter  int unsigned TAG_W  = TW_TAG_W,
  localparam int unsigned P_W    = prod_width(A_W, B_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   in_a,
  input  logic [B_W-1:0]   in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [P_W-1:0]   out_p,
  output logic [TAG_W-1:0] out_tag
);

  logic           adv;
  logic [P_W-1:0] a_ext;

  // Chain element k feeds stage k; element B_W is the final stage output.
  logic             vld_c [0:B_W];
  logic [P_W-1:0]   acc_c [0:B_W];
  logic [P_W-1:0]   a_c   [0:B_W];
  logic [B_W-1:0]   b_c   [0:B_W];
  logic [TAG_W-1:0] tag_c [0:B_W];

  // Global stall: the whole pipeline freezes while the output is held.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  generate
    if (SIGNED != 0) begin : g_sext
      assign a_ext = {{B_W{in_a[A_W-1]}}, in_a};
    end else begin : g_zext
      assign a_ext = {{B_W{1'b0}}, in_a};
    end
  endgenerate

  assign vld_c[0] = in_valid && in_ready;
  assign acc_c[0] = '0;
  assign a_c[0]   = a_ext;
  assign b_c[0]   = in_b;
  assign tag_c[0] = in_tag;

  generate
    for (genvar k = 0; k < B_W; k++) begin : g_stage
      mult_stage #(
        .P_W       (P_W),
        .B_W       (B_W),
        .TAG_W     (TAG_W),
        .IS_MSB_SUB((SIGNED != 0) && (k == B_W - 1))
      ) u_stage (
        .clk    (clk),
        .rst    (rst),
        .flush_i(flush),
        .adv_i  (adv),
        .valid_i(vld_c[k]),
        .acc_i  (acc_c[k]),
        .a_i    (a_c[k]),
        .b_i    (b_c[k]),
        .tag_i  (tag_c[k]),
        .valid_o(vld_c[k+1]),
        .acc_o  (acc_c[k+1]),
        .a_o    (a_c[k+1]),
        .b_o    (b_c[k+1]),
        .tag_o  (tag_c[k+1])
      );
    end
  endgenerate

  assign out_valid = vld_c[B_W];
  assign out_p     = acc_c[B_W];
  assign out_tag   = tag_c[B_W];

endmodule
